mem_arbiter: RTL

Two-port arbiter that shares the single SDRAM controller request interface (go / w_rn / address / 64-bit write data / 64-bit read data / valid) between two stream clients, e.g. the compression and encryption engines. Requests are granted round-robin, and each granted request is latched. The arbiter then issues a one-cycle go pulse to the controller, waits for valid, and returns read data plus a done pulse to the owning client. A watchdog flags controller hangs.

---
 rtl/mem_arbiter_if.sv | 22 ++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// SDRAM controller request bus shared by the arbiter (master) and the controller (slave).
interface mem_arbiter_if #(
    parameter int unsigned AW = 13,
    parameter int unsigned DW = 64
);
    logic          mem_go;
    logic          mem_w_rn;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_to_write;
    logic [DW-1:0] mem_data_to_read;
    logic          mem_valid;

    modport master (
        output mem_go, mem_w_rn, mem_address, mem_data_to_write,
        input  mem_data_to_read, mem_valid
    );

    modport slave (
        input  mem_go, mem_w_rn, mem_address, mem_data_to_write,
        output mem_data_to_read, mem_valid
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller request port between two
// stream clients, with a watchdog that aborts transactions the controller never completes.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned AW      = 13,
    parameter int unsigned DW      = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          w_rn0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic          done0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          w_rn1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic          done1,
    output logic [DW-1:0] rdata1,
    mem_arbiter_if.master bus,
    output logic          timeout_err
);
    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t        state, state_d;
    logic          owner, owner_d;
    logic          last, last_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          terr_d;
    logic          latch;
    logic          pick;
    logic          cap;

    // Next-state, arbitration and watchdog decisions
    always_comb begin
        state_d = state;
        owner_d = owner;
        last_d  = last;
        cnt_d   = cnt;
        terr_d  = timeout_err;
        latch   = 1'b0;
        pick    = 1'b0;
        cap     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    // On a tie the client that was not served last wins
                    pick    = req1 && (!req0 || !last);
                    owner_d = pick;
                    last_d  = pick;
                    latch   = 1'b1;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: state_d = ST_ISSUE;
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt + CW'(1);
                if (bus.mem_valid) begin
                    cap     = !bus.mem_w_rn;
                    state_d = ST_DONE;
                end else if (cnt == CW'(TIMEOUT - 2)) begin
                    terr_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, latched request fields and registered client/controller strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                 <= ST_IDLE;
            owner                 <= 1'b0;
            last                  <= 1'b1;
            cnt                   <= '0;
            timeout_err           <= 1'b0;
            ack0                  <= 1'b0;
            ack1                  <= 1'b0;
            done0                 <= 1'b0;
            done1                 <= 1'b0;
            rdata0                <= '0;
            rdata1                <= '0;
            bus.mem_go            <= 1'b0;
            bus.mem_w_rn          <= 1'b0;
            bus.mem_address       <= '0;
            bus.mem_data_to_write <= '0;
        end else begin
            state       <= state_d;
            owner       <= owner_d;
            last        <= last_d;
            cnt         <= cnt_d;
            timeout_err <= terr_d;
            ack0        <= (state_d == ST_GRANT) && !owner_d;
            ack1        <= (state_d == ST_GRANT) &&  owner_d;
            done0       <= (state_d == ST_DONE)  && !owner_d;
            done1       <= (state_d == ST_DONE)  &&  owner_d;
            bus.mem_go  <= (state_d == ST_ISSUE);
            if (latch) begin
                bus.mem_w_rn          <= pick ? w_rn1  : w_rn0;
                bus.mem_address       <= pick ? addr1  : addr0;
                bus.mem_data_to_write <= pick ? wdata1 : wdata0;
            end
            if (cap && !owner) rdata0 <= bus.mem_data_to_read;
            if (cap &&  owner) rdata1 <= bus.mem_data_to_read;
        end
    end
endmodule
